// File: rtl/addsub32_seq.sv
// Operand/result register stage around a combinational ripple add/sub.
// Optional feature macro: STICKY_OVF_EN (accumulated overflow flag with synchronous clear).
module addsub32_seq #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_ans,
  input  logic             add_cout,
  input  logic             add_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_ans,
  output logic             out_cout,
  output logic             out_v,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] LP_CNT_INIT = 8'(SETTLE - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_next;
  logic             w_accept;
  logic             w_capture;
  logic             w_consume;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_sub;
  logic [WIDTH-1:0] r_out_ans;
  logic             r_out_cout;
  logic             r_out_v;
  logic             r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_cnt_next   = LP_CNT_INIT;
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Adder outputs are only trusted once the full ripple window has elapsed.
        if (r_cnt == 8'd0) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_consume    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_sub <= 1'b0;
    end else if (w_accept) begin
      r_add_a   <= in_a;
      r_add_b   <= in_b;
      r_add_sub <= in_sub;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_ans   <= '0;
      r_out_cout  <= 1'b0;
      r_out_v     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_ans   <= add_ans;
        r_out_cout  <= add_cout;
        r_out_v     <= add_v;
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef STICKY_OVF_EN
  logic r_ovf_sticky;

  // A new overflow on the same edge as a clear must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_capture && add_v) begin
      r_ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = ovf_clr;
  assign ovf_sticky       = 1'b0;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_sub   = r_add_sub;
  assign out_valid = r_out_valid;
  assign out_ans   = r_out_ans;
  assign out_cout  = r_out_cout;
  assign out_v     = r_out_v;

endmodule

// File: tb/tb_addsub32_seq.sv
// Scoreboard bench for addsub32_seq with a slow-settling adder model that shows garbage until the ripple window ends.
module tb_addsub32_seq;
  localparam int W  = 32;
  localparam int ST = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, in_sub;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] add_a, add_b, add_ans;
  logic         add_sub, add_cout, add_v;
  logic         out_valid, out_ready, out_cout, out_v;
  logic [W-1:0] out_ans;
  logic         ovf_sticky, ovf_clr;

  addsub32_seq #(.WIDTH(W), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .add_ans(add_ans), .add_cout(add_cout), .add_v(add_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ans(out_ans), .out_cout(out_cout), .out_v(out_v),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: outputs are inverted (wrong) until operands have been stable long enough.
  logic [2*W:0] snap = '0;
  int           age = 0;
  always @(posedge clk) begin
    if ({add_a, add_b, add_sub} != snap) begin
      snap <= {add_a, add_b, add_sub};
      age  <= 0;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  logic [W-1:0] m_bb;
  logic [W:0]   m_sum;
  logic         m_good;
  always_comb begin
    m_bb   = add_sub ? ~add_b : add_b;
    m_sum  = {1'b0, add_a} + {1'b0, m_bb} + {{W{1'b0}}, add_sub};
    m_good = ({add_a, add_b, add_sub} == snap) && (age >= ST - 2);
    add_ans  = m_good ? m_sum[W-1:0] : ~m_sum[W-1:0];
    add_cout = m_good ? m_sum[W] : ~m_sum[W];
    add_v    = ((add_a[W-1] == m_bb[W-1]) && (m_sum[W-1] != add_a[W-1])) ^ !m_good;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] ans;
    logic         cout;
    logic         v;
    int           acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares each new result presentation against the oldest expected entry.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("out_ans", out_ans, e.ans);
            chk("out_cout", out_cout, e.cout);
            chk("out_v", out_v, e.v);
            chk("latency", cyc - e.acc, ST);
            $display("[TB] result ans=0x%08h cout=%0d v=%0d latency=%0d", out_ans, out_cout, out_v, cyc - e.acc);
          end
        end
        prev = out_valid;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic [W-1:0] ea, input logic ec, input logic ev,
                      input bit push, output int k);
    int guard;
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    k = cyc + 1;
    if (push) sb.push_back('{ea, ec, ev, k});
    $display("[TB] issue a=0x%08h b=0x%08h sub=%0d at edge %0d", a, b, sub, k);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(in_ready && !out_valid) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!(in_ready && !out_valid)) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int guard;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_sub", add_sub, 0);
    chk("rst_out_ans", out_ans, 0);
    chk("rst_out_cv", {out_cout, out_v}, 0);
    chk("rst_ovf_sticky", ovf_sticky, 0);
    rst_n = 1'b1;

    send(32'h00000021, 32'h00000022, 1'b0, 32'h00000043, 1'b0, 1'b0, 1'b1, k);
    wait_idle();

    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1, k);
    wait_idle();
`ifdef STICKY_OVF_EN
    chk("sticky_set", ovf_sticky, 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("sticky_cleared", ovf_sticky, 0);
    send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, k);
    while (cyc < k + ST - 1) @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("sticky_set_wins", ovf_sticky, 1);
    wait_idle();
`else
    chk("sticky_tied_low", ovf_sticky, 0);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, k);
    wait_idle();
    chk("sticky_tied_low2", ovf_sticky, 0);
`endif

    send(32'h336FB7E5, 32'h336FB7E5, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, k);
    for (int i = 0; i < ST; i++) begin
      chk("settle_add_b", add_b, 32'h336FB7E5);
      chk("settle_add_sub", add_sub, 1);
      @(negedge clk);
    end
    wait_idle();

    send(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, k);
    wait_idle();
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, k);
    wait_idle();
    send(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, k);
    wait_idle();

    // Backpressure with a pending request held on the input.
    out_ready = 1'b0;
    send(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b1, k);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_a = 32'h0000000A; in_b = 32'h00000003; in_sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_ans", out_ans, 32'h23456789);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_after_consume", in_ready, 1);
    sb.push_back('{32'h00000007, 1'b1, 1'b0, cyc + 1});
    $display("[TB] issue a=0x0000000a b=0x00000003 sub=1 at edge %0d", cyc + 1);
    @(negedge clk);
    chk("bp_accepted_next", in_ready, 0);
    in_valid = 1'b0;
    wait_idle();

    // Reset in the third SETTLE cycle aborts the operation.
    send(32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, k);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_add_a", add_a, 0);
    chk("mid_rst_add_b", add_b, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_ans", out_ans, 0);
    $display("[TB] reset asserted mid-settle at cycle %0d", cyc);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (ST + 4) @(negedge clk);
    chk("no_result_after_abort", out_valid, 0);
    send(32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0, 1'b0, 1'b1, k);
    wait_idle();

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
